// File: rtl/pu_msp430_per_master.sv
// Queued peripheral-bus master: commands are buffered in a small FIFO and replayed
// one at a time as single-cycle peripheral accesses, each returning one response.
module pu_msp430_per_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int WAIT_CYC   = 0
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [14:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   input  logic [1:0]  cmd_we,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_wr,
   output logic        per_en,
   output logic [1:0]  per_we,
   output logic [13:0] per_addr,
   output logic [15:0] per_din,
   input  logic [15:0] per_dout,
   output logic        busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [1:0]       WAIT_LAST = (WAIT_CYC > 0) ? 2'(WAIT_CYC - 1) : 2'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // Entry layout: {word address[31:18], write data[17:2], byte enables[1:0]}
   logic [31:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   state_t           state_r;
   state_t           state_s;
   logic [1:0]       wait_cnt_r;
   logic             push_s;
   logic             pop_s;
   logic             fifo_empty_s;
   logic [31:0]      head_s;
   logic [15:0]      capture_r;
   logic             rsp_wr_r;
   logic             rsp_valid_r;
   logic             per_en_r;
   logic [1:0]       per_we_r;
   logic [13:0]      per_addr_r;
   logic [15:0]      per_din_r;
   logic             addr_lsb_unused_s;

   assign addr_lsb_unused_s = cmd_addr[0];
   assign cmd_ready    = (count_r < DEPTH_C);
   assign push_s       = cmd_valid & cmd_ready;
   assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
   assign head_s       = fifo_mem_r[rd_ptr_r];
   assign busy         = (~fifo_empty_s) | (state_r != S_IDLE);

   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = capture_r;
   assign rsp_wr    = rsp_wr_r;
   assign per_en    = per_en_r;
   assign per_we    = per_we_r;
   assign per_addr  = per_addr_r;
   assign per_din   = per_din_r;

   // Next-state decode; the FIFO head is popped on every entry into ACC
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!fifo_empty_s) begin
               state_s = S_ACC;
               pop_s   = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ACC: begin
            if (WAIT_CYC > 0) begin
               state_s = S_WAIT;
            end else begin
               state_s = S_RESP;
            end
         end
         S_WAIT: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_s = S_RESP;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               if (!fifo_empty_s) begin
                  state_s = S_ACC;
                  pop_s   = 1'b1;
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               state_s = S_RESP;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // FSM state and wait-cycle counter
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state_r    <= S_IDLE;
         wait_cnt_r <= 2'd0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= (state_r == S_WAIT) ? (wait_cnt_r + 2'd1) : 2'd0;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while count is zero
   always_ff @(posedge mclk) begin
      if (push_s) fifo_mem_r[wr_ptr_r] <= {cmd_addr[14:1], cmd_wdata, cmd_we};
   end

   // Peripheral bus drivers: loaded on pop, forced to zero otherwise
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         per_en_r   <= 1'b0;
         per_we_r   <= 2'b00;
         per_addr_r <= 14'h0000;
         per_din_r  <= 16'h0000;
      end else if (pop_s) begin
         per_en_r   <= 1'b1;
         per_addr_r <= head_s[31:18];
         per_din_r  <= head_s[17:2];
         per_we_r   <= head_s[1:0];
      end else begin
         per_en_r   <= 1'b0;
         per_we_r   <= 2'b00;
         per_addr_r <= 14'h0000;
         per_din_r  <= 16'h0000;
      end
   end

   // Response capture at the end of ACC; valid tracks the RESP state
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         capture_r   <= 16'h0000;
         rsp_wr_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
      end else begin
         if (state_r == S_ACC) begin
            capture_r <= (per_we_r == 2'b00) ? per_dout : 16'h0000;
            rsp_wr_r  <= (per_we_r != 2'b00);
         end
         rsp_valid_r <= (state_s == S_RESP);
      end
   end

endmodule
